// File: rtl/master_control.sv
// Initiator side of the request/ack/valid board-to-board handshake with a programmable ack-to-valid delay.
// Latency: request 1 clk after send; valid DELAY_CYCLES clks after the synchronized ack is seen; ack path adds 2 sync flops.
// Backpressure: send is ignored while busy; the transfer stalls in REQ/SEND until the responder moves ack (REQ may abort when MASTER_ACK_TIMEOUT_EN is defined).
module master_control #(
    parameter int DATA_W         = 3,
    parameter int DELAY_CYCLES   = 100000000,
    parameter int CNT_W          = 27,
    parameter int TIMEOUT_CYCLES = 100000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              send,
    input  logic [DATA_W-1:0] data_sw,
    input  logic              ack,
    output logic              request,
    output logic              valid,
    output logic [DATA_W-1:0] data_out,
    output logic              notice,
    output logic              busy,
    output logic              timeout
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_DELAY = 2'd2;
    localparam logic [1:0] ST_SEND  = 2'd3;

    localparam logic [CNT_W-1:0] DELAY_LAST   = CNT_W'(DELAY_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

`ifdef MASTER_ACK_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              request_q, request_d;
    logic              valid_q, valid_d;
    logic              notice_q, notice_d;
    logic              timeout_q, timeout_d;
    logic              ack_meta_q, ack_meta_d;
    logic              ack_s_q, ack_s_d;

    // Next-state and registered-output logic; every output changes on the same edge as its state change.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hold_d     = hold_q;
        data_out_d = data_out_q;
        request_d  = request_q;
        valid_d    = valid_q;
        notice_d   = notice_q;
        timeout_d  = 1'b0;
        ack_meta_d = ack;
        ack_s_d    = ack_meta_q;
        case (state_q)
            ST_IDLE: begin
                request_d = 1'b0;
                valid_d   = 1'b0;
                notice_d  = 1'b0;
                if (send) begin
                    hold_d    = data_sw;
                    request_d = 1'b1;
                    notice_d  = 1'b1;
                    cnt_d     = '0;
                    state_d   = ST_REQ;
                end
            end
            ST_REQ: begin
                // A synchronized ack always wins over a coincident terminal count.
                if (ack_s_q) begin
                    request_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = ST_DELAY;
                end else if (TIMEOUT_EN) begin
                    if (cnt_q == TIMEOUT_LAST) begin
                        request_d = 1'b0;
                        notice_d  = 1'b0;
                        timeout_d = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_DELAY: begin
                // ack_s dropping here is ignored: the responder keeps ack up until it sees valid.
                if (cnt_q == DELAY_LAST) begin
                    data_out_d = hold_q;
                    valid_d    = 1'b1;
                    notice_d   = 1'b0;
                    state_d    = ST_SEND;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_SEND: begin
                if (!ack_s_q) begin
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                request_d = 1'b0;
                valid_d   = 1'b0;
                notice_d  = 1'b0;
            end
        endcase
    end

    // State, counter, data and output registers plus the two-flop ack synchronizer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            hold_q     <= '0;
            data_out_q <= '0;
            request_q  <= 1'b0;
            valid_q    <= 1'b0;
            notice_q   <= 1'b0;
            timeout_q  <= 1'b0;
            ack_meta_q <= 1'b0;
            ack_s_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hold_q     <= hold_d;
            data_out_q <= data_out_d;
            request_q  <= request_d;
            valid_q    <= valid_d;
            notice_q   <= notice_d;
            timeout_q  <= timeout_d;
            ack_meta_q <= ack_meta_d;
            ack_s_q    <= ack_s_d;
        end
    end

    assign request  = request_q;
    assign valid    = valid_q;
    assign data_out = data_out_q;
    assign notice   = notice_q;
    assign timeout  = timeout_q;
    assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_master_control.sv
// Bench for master_control: timing of each transfer is predicted as edge numbers from when the
// bench drove send/ack, plus a small per-transfer scoreboard of the value that must arrive.
module tb_master_control;

    localparam int DLY = 4;
    localparam int TMO = 20;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       send;
    logic [2:0] data_sw;
    logic       ack;
    logic       request, valid, notice, busy, timeout;
    logic [2:0] data_out;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic [2:0] last_d = 3'b000;

    master_control #(
        .DATA_W(3), .DELAY_CYCLES(DLY), .CNT_W(27), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .send(send), .data_sw(data_sw), .ack(ack),
        .request(request), .valid(valid), .data_out(data_out),
        .notice(notice), .busy(busy), .timeout(timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [2:0] d;          // value presented with send
        int         ack_dly;    // cycles from send drive to ack raise
        int         ack_hold;   // cycles after valid is seen before ack drops
        bit         alt_send;   // extra send with other data while in REQ
        bit         sw_chg;     // change data_sw during DELAY
        logic [2:0] sw_val;
        bit         edge_send;  // send landing on the SEND->IDLE edge
        logic [2:0] exp_data;   // value that must be delivered
        int         exp_rfall;  // request fall, edges after send drive
        int         exp_vrise;  // valid rise, edges after send drive
    } xfer_t;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // One full transfer with a responder that raises ack after ack_dly and drops it ack_hold after valid.
    // The synchronizer takes two edges and the registered response a third, so a change of ack driven
    // between edges c and c+1 shows up on the outputs after edge c+3.
    task automatic run_xfer(input xfer_t v);
        int t0, ta, tl, r_up, r_dn, v_up, v_dn, nreq, ovl;
        logic prev_req, prev_val, n_rdn, n_vup, b_rup;
        logic [2:0] d_vup;
        t0 = cyc; ta = t0 + v.ack_dly; tl = -1;
        r_up = -1; r_dn = -1; v_up = -1; v_dn = -1; nreq = 0; ovl = 0;
        n_rdn = 1'b0; n_vup = 1'b1; b_rup = 1'b0; d_vup = 3'b000;
        prev_req = request; prev_val = valid;
        for (int k = 0; k < 300 && v_dn < 0; k++) begin
            send = 1'b0;
            if (cyc == t0) begin send = 1'b1; data_sw = v.d; end
            if (v.alt_send && cyc == t0 + 2) begin send = 1'b1; data_sw = v.d ^ 3'b111; end
            if (v.sw_chg && cyc == ta + 4) data_sw = v.sw_val;
            if (cyc == ta) ack = 1'b1;
            if (tl >= 0 && cyc == tl) ack = 1'b0;
            if (v.edge_send && tl >= 0 && cyc == tl + 2) begin send = 1'b1; data_sw = 3'b110; end
            @(negedge clk);
            if (request && !prev_req) begin nreq++; if (r_up < 0) begin r_up = cyc; b_rup = busy; end end
            if (!request && prev_req && r_dn < 0) begin r_dn = cyc; n_rdn = notice; end
            if (valid && !prev_val && v_up < 0) begin
                v_up = cyc; d_vup = data_out; n_vup = notice; tl = cyc + v.ack_hold;
            end
            if (!valid && prev_val && v_dn < 0) v_dn = cyc;
            if (request && valid) ovl++;
            prev_req = request; prev_val = valid;
        end
        send = 1'b0;
        chk("req_rise",      r_up, t0 + 1);
        chk("busy_in_req",   int'(b_rup), 1);
        chk("req_fall",      r_dn, t0 + v.exp_rfall);
        chk("notice_delay",  int'(n_rdn), 1);
        chk("valid_rise",    v_up, t0 + v.exp_vrise);
        chk("notice_send",   int'(n_vup), 0);
        chk("data_at_valid", int'(d_vup), int'(v.exp_data));
        chk("valid_fall",    v_dn, (tl < 0) ? 0 : tl + 3);
        chk("data_after",    int'(data_out), int'(v.exp_data));
        chk("busy_after",    int'(busy), 0);
        chk("one_request",   nreq, 1);
        chk("req_val_excl",  ovl, 0);
        if (v.edge_send) begin
            repeat (2) begin
                @(negedge clk);
                chk("edge_send_req", int'(request), 0);
                chk("edge_send_busy", int'(busy), 0);
            end
        end
        last_d = v.exp_data;
    endtask

    xfer_t tbl[7];
    xfer_t rv;
    int    reqcnt, tocnt, tpos, gap;
    bit    found;

    initial begin
        // d, ack_dly, ack_hold, alt, sw_chg, sw_val, edge_send, exp_data, exp_rfall, exp_vrise
        tbl[0] = '{3'b101, 10, 2, 1'b0, 1'b0, 3'b000, 1'b0, 3'b101, 13, 13 + DLY}; // normal
        tbl[1] = '{3'b101, 10, 2, 1'b1, 1'b0, 3'b000, 1'b0, 3'b101, 13, 13 + DLY}; // busy rejection
        tbl[2] = '{3'b101, 10, 2, 1'b0, 1'b1, 3'b111, 1'b0, 3'b101, 13, 13 + DLY}; // data stability
        tbl[3] = '{3'b011,  6, 2, 1'b0, 1'b0, 3'b000, 1'b0, 3'b011,  9,  9 + DLY}; // back-to-back
        tbl[4] = '{3'b010,  5, 3, 1'b0, 1'b0, 3'b000, 1'b1, 3'b010,  8,  8 + DLY}; // send on return edge
        tbl[5] = '{3'b110, 18, 1, 1'b0, 1'b0, 3'b000, 1'b0, 3'b110, 21, 21 + DLY}; // ack on terminal count
        tbl[6] = '{3'b001,  2, 1, 1'b0, 1'b0, 3'b000, 1'b0, 3'b001,  5,  5 + DLY}; // fastest responder

        rst_n = 1'b0; send = 1'b0; data_sw = 3'b000; ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_request", int'(request), 0);
        chk("rst_valid",   int'(valid), 0);
        chk("rst_notice",  int'(notice), 0);
        chk("rst_busy",    int'(busy), 0);
        chk("rst_timeout", int'(timeout), 0);
        chk("rst_data",    int'(data_out), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_busy", int'(busy), 0);

        for (int i = 0; i < 7; i++) run_xfer(tbl[i]);

        // Randomized transfers with random gaps and data_sw noise between them.
        for (int i = 0; i < 25; i++) begin
            gap = $urandom_range(3, 0);
            for (int g = 0; g < gap; g++) begin
                data_sw = 3'($urandom);
                @(negedge clk);
            end
            rv.d         = 3'($urandom);
            rv.ack_dly   = $urandom_range(15, 3);
            rv.ack_hold  = $urandom_range(5, 1);
            rv.alt_send  = 1'($urandom);
            rv.sw_chg    = 1'($urandom);
            rv.sw_val    = 3'($urandom);
            rv.edge_send = 1'($urandom);
            rv.exp_data  = rv.d;
            rv.exp_rfall = rv.ack_dly + 3;
            rv.exp_vrise = rv.ack_dly + 3 + DLY;
            run_xfer(rv);
        end

        // Responder never answers.
        data_sw = 3'b001; send = 1'b1;
        @(negedge clk);
        send = 1'b0; reqcnt = 0; tocnt = 0; tpos = -1;
        for (int k = 0; k < 40; k++) begin
            if (request) reqcnt++;
            if (timeout) begin tocnt++; tpos = k; end
            @(negedge clk);
        end
`ifdef MASTER_ACK_TIMEOUT_EN
        chk("tmo_req_cycles", reqcnt, TMO);
        chk("tmo_pulses",     tocnt, 1);
        chk("tmo_pulse_pos",  tpos, TMO);
        chk("tmo_busy",       int'(busy), 0);
`else
        chk("tmo_req_held",   reqcnt, 40);
        chk("tmo_none",       tocnt, 0);
        chk("tmo_busy",       int'(busy), 1);
`endif
        chk("tmo_data",       int'(data_out), int'(last_d));
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_from_req", int'(request), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset landing mid-SEND must clear outputs without a clock edge.
        data_sw = 3'b100; send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        repeat (2) @(negedge clk);
        ack = 1'b1; found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk);
            if (valid) found = 1'b1;
        end
        chk("reach_send", int'(found), 1);
        #2 rst_n = 1'b0; ack = 1'b0;
        #1;
        chk("async_request", int'(request), 0);
        chk("async_valid",   int'(valid), 0);
        chk("async_busy",    int'(busy), 0);
        chk("async_notice",  int'(notice), 0);
        chk("async_data",    int'(data_out), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_idle", int'(busy | request | valid), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
